// File: rtl/ysyx_210184_trap_ctrl_if.sv
// Fetch redirect / flush bundle between the trap sequencer and instruction fetch.
//   redirect_valid_o : trap sequencer requests a PC redirect
//   redirect_pc_o    : redirect target, word aligned, stable while valid
//   redirect_ready_i : fetch accepts the redirect
//   flush_o          : pipeline flush, high on the handshake cycle
// Modports: master = trap sequencer, slave = fetch.
interface ysyx_210184_trap_ctrl_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            redirect_ready_i;
  logic            flush_o;

  modport master (
    output redirect_valid_o,
    output redirect_pc_o,
    output flush_o,
    input  redirect_ready_i
  );

  modport slave (
    input  redirect_valid_o,
    input  redirect_pc_o,
    input  flush_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/ysyx_210184_trap_ctrl.sv
// Trap sequencer between commit, the CSR file and instruction fetch.
// Qualifies pending machine interrupts (mtime > ext > software), waits for a
// committing instruction, pulses a one-hot take strobe to the CSR file, then
// redirects fetch to mtvec. ecall/mret redirect to mtvec/mepc directly.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   MIE/MTIE/MEIE/MSIE             : mstatus.MIE and mie enables
//   mtime/ext/software_intr_i      : raw pending levels
//   inst_valid, is_ecall, is_mret  : commit-stage information
//   commit_next_pc_i               : next PC of the committing instruction
//   csr_mtvec_i, csr_mepc_i        : trap vector and exception PC
//   *_intr_enable_o, pc_intr_o     : take strobe and mepc value to the CSR file
//   stall_o                        : holds commit while a trap is sequenced
//   redir                          : fetch redirect handshake and flush
// Build option: YSYX_210184_EXT_INTR_SYNC_EN adds a 2-flop synchronizer on ext_intr_i.
module ysyx_210184_trap_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MIE,
  input  logic            MTIE,
  input  logic            MEIE,
  input  logic            MSIE,
  input  logic            mtime_intr_i,
  input  logic            ext_intr_i,
  input  logic            software_intr_i,
  input  logic            inst_valid,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic [XLEN-1:0] commit_next_pc_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            mtime_intr_enable_o,
  output logic            ext_intr_enable_o,
  output logic            software_intr_enable_o,
  output logic [XLEN-1:0] pc_intr_o,
  output logic            stall_o,
  ysyx_210184_trap_ctrl_if.master redir
);

  typedef enum logic [2:0] {StIdle, StArmed, StTake, StRedir, StSettle} state_e;

  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;      // {mtime, ext, software}
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] pc_intr_q, pc_intr_d;
  logic            ext_pend;
  logic [2:0]      qp, pick;
  logic            sync_evt;
  logic [XLEN-1:0] sync_tgt;

`ifdef YSYX_210184_EXT_INTR_SYNC_EN
  logic ext_meta_q, ext_sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
    end else begin
      ext_meta_q <= ext_intr_i;
      ext_sync_q <= ext_meta_q;
    end
  end
  assign ext_pend = ext_sync_q;
`else
  assign ext_pend = ext_intr_i;
`endif

  assign qp = {3{MIE}} & {mtime_intr_i & MTIE, ext_pend & MEIE, software_intr_i & MSIE};

  // Fixed priority, same order as mcause selection in the CSR file.
  always_comb begin
    pick = 3'b000;
    if (qp[2])      pick = 3'b100;
    else if (qp[1]) pick = 3'b010;
    else if (qp[0]) pick = 3'b001;
  end

  // ecall has precedence over mret if both were ever flagged together.
  assign sync_evt = inst_valid & (is_ecall | is_mret);
  assign sync_tgt = is_ecall ? csr_mtvec_i : csr_mepc_i;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    target_d  = target_q;
    pc_intr_d = pc_intr_q;
    unique case (state_q)
      StIdle: begin
        if (sync_evt) begin
          state_d  = StRedir;
          target_d = sync_tgt & AlignMask;
        end else if (|qp) begin
          state_d = StArmed;
          sel_d   = pick;
        end
      end
      StArmed: begin
        // Synchronous traps win; the interrupt is re-evaluated after SETTLE.
        if (sync_evt) begin
          state_d  = StRedir;
          target_d = sync_tgt & AlignMask;
          sel_d    = 3'b000;
        end else if (~|qp) begin
          state_d = StIdle;
          sel_d   = 3'b000;
        end else begin
          sel_d = pick;
          if (inst_valid) begin
            state_d   = StTake;
            pc_intr_d = commit_next_pc_i;
          end
        end
      end
      StTake: begin
        state_d  = StRedir;
        target_d = csr_mtvec_i & AlignMask;
      end
      StRedir: begin
        if (redir.redirect_ready_i) state_d = StSettle;
      end
      StSettle: begin
        state_d = StIdle;
        sel_d   = 3'b000;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= 3'b000;
      target_q  <= '0;
      pc_intr_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      target_q  <= target_d;
      pc_intr_q <= pc_intr_d;
    end
  end

  // Outputs decode the registered state, so reset clears them immediately.
  assign mtime_intr_enable_o    = (state_q == StTake) & sel_q[2];
  assign ext_intr_enable_o      = (state_q == StTake) & sel_q[1];
  assign software_intr_enable_o = (state_q == StTake) & sel_q[0];
  assign pc_intr_o              = pc_intr_q;
  assign stall_o                = (state_q == StTake) | (state_q == StRedir) |
                                  (state_q == StSettle);
  assign redir.redirect_valid_o = (state_q == StRedir);
  assign redir.redirect_pc_o    = target_q;
  assign redir.flush_o          = (state_q == StRedir) & redir.redirect_ready_i;

endmodule

// File: tb/tb_ysyx_210184_trap_ctrl.sv
module tb_ysyx_210184_trap_ctrl;

`ifdef YSYX_210184_EXT_INTR_SYNC_EN
  localparam int ExtLat = 4;
`else
  localparam int ExtLat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MIE, MTIE, MEIE, MSIE;
  logic        mtime_intr_i, ext_intr_i, software_intr_i;
  logic        inst_valid, is_ecall, is_mret;
  logic [63:0] commit_next_pc_i, csr_mtvec_i, csr_mepc_i;
  logic        mtime_intr_enable_o, ext_intr_enable_o, software_intr_enable_o;
  logic [63:0] pc_intr_o;
  logic        stall_o;

  int n_chk = 0;
  int n_err = 0;

  ysyx_210184_trap_ctrl_if #(.XLEN(64)) rif ();

  ysyx_210184_trap_ctrl #(.XLEN(64)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .MIE                    (MIE),
    .MTIE                   (MTIE),
    .MEIE                   (MEIE),
    .MSIE                   (MSIE),
    .mtime_intr_i           (mtime_intr_i),
    .ext_intr_i             (ext_intr_i),
    .software_intr_i        (software_intr_i),
    .inst_valid             (inst_valid),
    .is_ecall               (is_ecall),
    .is_mret                (is_mret),
    .commit_next_pc_i       (commit_next_pc_i),
    .csr_mtvec_i            (csr_mtvec_i),
    .csr_mepc_i             (csr_mepc_i),
    .mtime_intr_enable_o    (mtime_intr_enable_o),
    .ext_intr_enable_o      (ext_intr_enable_o),
    .software_intr_enable_o (software_intr_enable_o),
    .pc_intr_o              (pc_intr_o),
    .stall_o                (stall_o),
    .redir                  (rif.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [2:0] strobes();
    return {mtime_intr_enable_o, ext_intr_enable_o, software_intr_enable_o};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_strobe"}, 64'(strobes()), 64'd0);
    check_eq({tag, "_pc_intr"}, pc_intr_o, 64'd0);
    check_eq({tag, "_rvalid"}, 64'(rif.redirect_valid_o), 64'd0);
    check_eq({tag, "_rpc"}, rif.redirect_pc_o, 64'd0);
    check_eq({tag, "_flush"}, 64'(rif.flush_o), 64'd0);
    check_eq({tag, "_stall"}, 64'(stall_o), 64'd0);
  endtask

  // Drive one interrupt scenario with fetch always ready; expects exactly one
  // strobe of value exp_sel in cycle exp_cycle and exactly one flush.
  task automatic run_trap(input string tag, input logic [2:0] en, input logic [2:0] pend,
                          input logic [2:0] exp_sel, input int iv_delay, input int exp_cycle,
                          input logic [63:0] pc);
    int n_strobe = 0;
    int n_flush  = 0;
    MIE = 1'b1;
    {MTIE, MEIE, MSIE} = en;
    {mtime_intr_i, ext_intr_i, software_intr_i} = pend;
    commit_next_pc_i = pc;
    rif.redirect_ready_i = 1'b1;
    inst_valid = (iv_delay == 0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (rif.flush_o) n_flush++;
      if (|strobes()) begin
        if (n_strobe == 0) begin
          check_eq({tag, "_sel"}, 64'(strobes()), 64'(exp_sel));
          check_eq({tag, "_cycle"}, 64'(c), 64'(exp_cycle));
          check_eq({tag, "_pc_intr"}, pc_intr_o, pc);
        end
        n_strobe++;
        {mtime_intr_i, ext_intr_i, software_intr_i} = 3'b000;
        inst_valid = 1'b0;
      end else if (c == iv_delay) begin
        inst_valid = 1'b1;
      end
    end
    check_eq({tag, "_nstrobe"}, 64'(n_strobe), 64'd1);
    check_eq({tag, "_nflush"}, 64'(n_flush), 64'd1);
    check_eq({tag, "_idle"}, 64'(stall_o), 64'd0);
    MIE = 1'b0;
    rif.redirect_ready_i = 1'b0;
  endtask

  initial begin
    {MIE, MTIE, MEIE, MSIE} = 4'b0;
    {mtime_intr_i, ext_intr_i, software_intr_i} = 3'b0;
    {inst_valid, is_ecall, is_mret} = 3'b0;
    commit_next_pc_i = '0;
    csr_mtvec_i = '0;
    csr_mepc_i = '0;
    rif.redirect_ready_i = 1'b0;

    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Basic mtime take with fetch stalling the redirect for 4 cycles.
    MIE = 1'b1; MTIE = 1'b1; mtime_intr_i = 1'b1; inst_valid = 1'b1;
    commit_next_pc_i = 64'h8000_0010; csr_mtvec_i = 64'h8000_0100;
    tick();
    check_eq("armed_strobe", 64'(strobes()), 64'd0);
    check_eq("armed_stall", 64'(stall_o), 64'd0);
    tick();
    check_eq("take_strobe", 64'(strobes()), 64'b100);
    check_eq("take_pc_intr", pc_intr_o, 64'h8000_0010);
    check_eq("take_stall", 64'(stall_o), 64'd1);
    check_eq("take_rvalid", 64'(rif.redirect_valid_o), 64'd0);
    mtime_intr_i = 1'b0; MIE = 1'b0; inst_valid = 1'b0;
    tick();
    check_eq("redir_strobe", 64'(strobes()), 64'd0);
    check_eq("redir_rvalid", 64'(rif.redirect_valid_o), 64'd1);
    check_eq("redir_rpc", rif.redirect_pc_o, 64'h8000_0100);
    check_eq("redir_flush", 64'(rif.flush_o), 64'd0);
    csr_mtvec_i = 64'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_rvalid", 64'(rif.redirect_valid_o), 64'd1);
      check_eq("hold_rpc", rif.redirect_pc_o, 64'h8000_0100);
      check_eq("hold_flush", 64'(rif.flush_o), 64'd0);
    end
    rif.redirect_ready_i = 1'b1;
    #1;
    check_eq("hs_flush", 64'(rif.flush_o), 64'd1);
    check_eq("hs_rvalid", 64'(rif.redirect_valid_o), 64'd1);
    tick();
    rif.redirect_ready_i = 1'b0;
    check_eq("settle_rvalid", 64'(rif.redirect_valid_o), 64'd0);
    check_eq("settle_flush", 64'(rif.flush_o), 64'd0);
    check_eq("settle_stall", 64'(stall_o), 64'd1);
    tick();
    check_eq("post_stall", 64'(stall_o), 64'd0);

    // Priority and late-arriving higher priority while ARMED.
    csr_mtvec_i = 64'h8000_0100;
    run_trap("prio_all", 3'b111, 3'b111, 3'b100, 0, 2, 64'h8000_1000);
    run_trap("prio_ext", 3'b011, 3'b111, 3'b010, 3, 4, 64'h8000_2000);
    run_trap("prio_sw", 3'b001, 3'b111, 3'b001, 0, 2, 64'h8000_3000);
    run_trap("ext_lat", 3'b010, 3'b010, 3'b010, 0, ExtLat, 64'h8000_4000);

    // ecall with a concurrent interrupt: ecall wins, no strobe.
    MIE = 1'b1; MTIE = 1'b1; mtime_intr_i = 1'b1;
    csr_mtvec_i = 64'h8000_0200; inst_valid = 1'b1; is_ecall = 1'b1;
    tick();
    inst_valid = 1'b0; is_ecall = 1'b0; mtime_intr_i = 1'b0; MIE = 1'b0;
    check_eq("ecall_rvalid", 64'(rif.redirect_valid_o), 64'd1);
    check_eq("ecall_rpc", rif.redirect_pc_o, 64'h8000_0200);
    check_eq("ecall_strobe", 64'(strobes()), 64'd0);
    rif.redirect_ready_i = 1'b1;
    tick();
    rif.redirect_ready_i = 1'b0;
    check_eq("ecall_settle", 64'(stall_o), 64'd1);
    tick();

    // mret with a misaligned mepc: low two bits dropped.
    csr_mepc_i = 64'h8000_0047; inst_valid = 1'b1; is_mret = 1'b1;
    tick();
    inst_valid = 1'b0; is_mret = 1'b0;
    check_eq("mret_rvalid", 64'(rif.redirect_valid_o), 64'd1);
    check_eq("mret_rpc", rif.redirect_pc_o, 64'h8000_0044);
    rif.redirect_ready_i = 1'b1;
    tick();
    rif.redirect_ready_i = 1'b0;
    tick();

    // Global MIE clear masks everything.
    MIE = 1'b0; {MTIE, MEIE, MSIE} = 3'b111;
    {mtime_intr_i, ext_intr_i, software_intr_i} = 3'b111; inst_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("mie0_strobe", 64'(strobes()), 64'd0);
      check_eq("mie0_stall", 64'(stall_o), 64'd0);
    end
    {mtime_intr_i, ext_intr_i, software_intr_i} = 3'b000; inst_valid = 1'b0;

    // Pending dropped while ARMED: nothing taken afterwards.
    MIE = 1'b1; mtime_intr_i = 1'b1;
    tick();
    mtime_intr_i = 1'b0;
    tick();
    inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("drop_strobe", 64'(strobes()), 64'd0);
      check_eq("drop_stall", 64'(stall_o), 64'd0);
    end
    inst_valid = 1'b0;

    // Asynchronous reset in the TAKE cycle.
    mtime_intr_i = 1'b1; inst_valid = 1'b1; commit_next_pc_i = 64'h8000_0abc;
    tick();
    tick();
    check_eq("rst_pre_strobe", 64'(strobes()), 64'b100);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    mtime_intr_i = 1'b0; inst_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_strobe", 64'(strobes()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
